// File: rtl/led_pkg.sv
// led_pkg: mode encoding, reset defaults and parameter legality check for led_blink_array.
package led_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_FLASH} led_mode_t;
  localparam led_mode_t RST_MODE = MODE_BLINK;
  localparam logic RST_PHASE = 1'b1;
  function automatic bit params_ok(input int clk_hz, input int tick_hz, input int n_ch);
    return tick_hz > 0 && clk_hz % tick_hz == 0 && clk_hz / tick_hz >= 2 && n_ch >= 1 && n_ch <= 16;
  endfunction
endpackage

// File: rtl/led_blink_array_if.sv
// led_blink_array_if: channel configuration write and sync strobe bus.
interface led_blink_array_if #(parameter int HP_W = 16);
  logic cfg_we;
  logic [3:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [HP_W-1:0] cfg_half;
  logic sync_all;
  modport master(output cfg_we, cfg_ch, cfg_mode, cfg_half, sync_all);
  modport slave(input cfg_we, cfg_ch, cfg_mode, cfg_half, sync_all);
endinterface

// File: rtl/led_channel.sv
// led_channel: one LED with its own mode, half-period, tick counter and phase.
module led_channel
  import led_pkg::*;
#(
  parameter int HP_W = 16,
  parameter int RST_HALF = 1000
) (
  input logic clk,
  input logic rst,
  input logic tick,
  input logic wr,
  input logic sync,
  input led_mode_t mode_in,
  input logic [HP_W-1:0] half_in,
  output logic led
);
  led_mode_t mode, mode_n;
  logic [HP_W-1:0] half, half_n, cnt, cnt_n;
  logic phase, phase_n, run, last, restart, led_n;
  always_comb begin
    run = mode == MODE_BLINK || mode == MODE_FLASH;
    last = cnt == ((half == '0) ? '0 : half - 1'b1);
    restart = wr || sync || !run;
    mode_n = wr ? mode_in : mode;
    half_n = wr ? half_in : half;
    cnt_n = restart ? '0 : tick ? (last ? '0 : cnt + 1'b1) : cnt;
    phase_n = restart ? RST_PHASE : (tick && last) ? ~phase : phase;
    // LED is computed from the next state so a write or sync shows right after its edge
    led_n = (mode_n == MODE_ON) | (phase_n & ((mode_n == MODE_BLINK) | ((mode_n == MODE_FLASH) & (cnt_n == '0))));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode <= RST_MODE;
      half <= HP_W'(RST_HALF);
      cnt <= '0;
      phase <= RST_PHASE;
      led <= 1'b1;
    end else begin
      mode <= mode_n;
      half <= half_n;
      cnt <= cnt_n;
      phase <= phase_n;
      led <= led_n;
    end
endmodule

// File: rtl/led_blink_array.sv
// led_blink_array: shared prescaler driving N_CH independently configured LED channels.
module led_blink_array
  import led_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH = 4,
  parameter int HP_W = 16,
  parameter int RST_HALF = 1000
) (
  input logic CLOCK_50,
  input logic RESET,
  led_blink_array_if.slave cfg,
  output logic [N_CH-1:0] LEDG,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = $clog2(DIV);
  if (!params_ok(CLK_HZ, TICK_HZ, N_CH)) begin : g_bad_params
    $error("led_blink_array: CLK_HZ must be a multiple of TICK_HZ, DIV >= 2, N_CH in 1..16");
  end
  logic [PW-1:0] pre;
  assign tick = pre == PW'(DIV - 1);
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    led_channel #(.HP_W(HP_W), .RST_HALF(RST_HALF)) u_ch (
      .clk(CLOCK_50),
      .rst(RESET),
      .tick(tick),
      .wr(cfg.cfg_we && cfg.cfg_ch == 4'(c)),
      .sync(cfg.sync_all),
      .mode_in(led_mode_t'(cfg.cfg_mode)),
      .half_in(cfg.cfg_half),
      .led(LEDG[c])
    );
  end
endmodule

// File: doc/led_blink_array.md
# led_blink_array

Parametrised multi-channel LED driver for the board's green LED bank, running from `CLOCK_50`. A shared prescaler generates a millisecond-class tick. Each channel has its own mode and half-period, programmed through a one-cycle write strobe, and every channel can be phase-realigned with a single sync pulse. It sits between board-level control logic and the `LEDG` pins, and replaces fixed single-rate blinkers.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 1000: prescaler tick rate. `DIV = CLK_HZ/TICK_HZ`; `CLK_HZ % TICK_HZ` must be 0 and `DIV >= 2` (elaboration-time check).
- `N_CH`, default 4: number of channels/LEDs, range 1..16.
- `HP_W`, default 16: width of the half-period field, in ticks.
- `RST_HALF`, default 1000: half-period loaded at reset.

- `CLOCK_50` input, 1: sole clock, rising edge.
- `RESET` input, 1: asynchronous, active-high reset.
- `cfg_we` input, 1: one-cycle configuration write strobe.
- `cfg_ch` input, 4: target channel index.
- `cfg_mode` input, 2: 0=OFF, 1=ON, 2=BLINK, 3=FLASH.
- `cfg_half` input, `HP_W`: half-period in ticks.
- `sync_all` input, 1: one-cycle strobe that restarts every channel.
- `LEDG` output, `N_CH`: registered LED drive, 1 = lit.
- `tick` output, 1: one-cycle prescaler pulse, for downstream reuse.

## Operation
- **Prescaler**
  - Counts 0..DIV-1 and wraps.
  - `tick`=1 during the cycle in which the count equals DIV-1, so there is exactly one tick every DIV cycles.
- **Channel state:** `mode`, `half`, tick counter `cnt` (0..half-1) and `phase`.
- **On a tick, for modes BLINK and FLASH:**
  - if `cnt == half_eff-1`: `cnt` ← 0 and `phase` toggles;
  - otherwise `cnt` increments.
  - `half_eff = (half==0) ? 1 : half`.
- **OFF and ON:** `cnt` and `phase` are held at 0 and 1.
- **LED output per mode:**
  - OFF: 0.
  - ON: 1.
  - BLINK: `phase`.
  - FLASH: `phase & (cnt==0)`, i.e. lit only for the first tick of each on-phase.
- **Write (`cfg_we`=1 and `cfg_ch < N_CH`):**
  - the addressed channel loads `mode` and `half`;
  - `cnt` ← 0 and `phase` ← 1.
  - `cfg_ch >= N_CH` is ignored with no state change.
- **`sync_all`=1:** every channel sets `cnt` ← 0 and `phase` ← 1. Mode and half are kept.
- **Priority for a channel in one cycle:** write > sync > tick update.
- **Simultaneous `cfg_we` and `sync_all`:** the addressed channel takes the new config and restarts; all other channels restart.
- **Reset:**
  - prescaler = 0 and `tick` = 0;
  - every channel: mode=BLINK, `half`=RST_HALF, `cnt`=0, `phase`=1;
  - hence `LEDG` is all ones.
- **Reset mid-operation:** reset asserted at any time forces the reset state immediately, without waiting for a clock edge.

## Timing
- `LEDG` is registered. A write or sync at edge k is visible on `LEDG` after edge k.
- The prescaler is free-running and is not restarted by a write or sync.
- **BLINK with half H, after a write:**
  - first toggle occurs between `(H-1)·DIV+1` and `H·DIV` cycles after the write edge;
  - every later toggle is exactly `H·DIV` cycles apart.
- **FLASH:** lit for exactly DIV cycles per period. The first lit interval starts at the write edge and can be shorter than DIV, ending at the next tick.
- `half` wrap: the counter is `HP_W` bits wide, and `half=2^HP_W-1` is legal with no overflow.

## Structure
- Package `led_pkg` holds:
  - the 2-bit mode enum `led_mode_t` (OFF/ON/BLINK/FLASH);
  - reset-default constants;
  - the parameter-legality check function.
- Sub-module `led_channel`:
  - one instance per channel, generated N_CH times;
  - inputs: `tick`, `wr`, `sync`, mode and half;
  - holds mode, half, `cnt` and `phase`, and drives one registered LED bit.
- Prescaler is inline in the top level.

## Test plan
All scenarios use CLK_HZ=20, TICK_HZ=2 (DIV=10), N_CH=4, RST_HALF=3.
- **Reset:** assert RESET mid-cycle → `LEDG`=4'b1111 and `tick`=0 asynchronously. After release, `tick` pulses every 10 cycles and each LED toggles every 30 cycles.
- **Write ch2 BLINK half=1 just after a tick:** ch2 goes high at once and toggles every 10 cycles. Channels 0, 1 and 3 are unaffected.
- **FLASH and half=0:**
  - write ch0 FLASH half=2 → high for at most one tick, low for 3 ticks, then a repeating 10-cycle high / 30-cycle low pattern;
  - write ch0 half=0 → behaves as half=1.
- **OFF/ON and bad index:**
  - ch1 OFF → 0; ch1 ON → 1, held across 100 cycles;
  - write to `cfg_ch`=5 → no change on any channel.
- **Sync:**
  - with channels out of phase, pulse `sync_all` → all BLINK LEDs = 1 on the next cycle, then toggling in lockstep;
  - `sync_all` together with a ch3 write → ch3 takes the new config and the others restart.
- **Tick collision:** `cfg_we` on the same cycle as `tick` → the write wins, giving `cnt`=0 and `phase`=1 with no extra toggle.
